// File: rtl/mux4_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and helpers for the round-robin 4:1 mux arbiter.
//   NUM_REQ  : number of requesters sharing the mux (4)
//   IDX_W    : width of a requester index (2)
//   arb_state_t : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   pick_t   : result of a round-robin search {found, idx}
//   rr_pick  : round-robin search over req starting after base
// -----------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Search order is base+1, base+2, base+3, base (mod 4), so base itself is
    // eligible last. Iterating from the last candidate down to the first lets
    // the earliest hit overwrite any later one.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   base);
        pick_t            r;
        logic [IDX_W-1:0] c;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = base + IDX_W'(k);
            if (req[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// -----------------------------------------------------------------------------
// mux4
// Plain combinational 4:1 one-bit selector.
//   a, b, c, d        : data inputs (index 0..3)
//   select0, select1  : select LSB / MSB
//   out               : selected data bit
// -----------------------------------------------------------------------------
module mux4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic select0,
    input  logic select1,
    output logic out
);

    always_comb begin
        out = a;
        case ({select1, select0})
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing a 4:1 one-bit mux among four requesters, with
// tenure bounded to MAX_BURST cycles per grant.
//   MAX_BURST  : max consecutive cycles one requester holds the grant (1..16)
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   lock       : (only with MUX4_ARB_LOCK_EN) keeps the grant past MAX_BURST
//   req[3:0]   : per-requester request, index 0 = mux input a
//   din[3:0]   : data bits {d,c,b,a}
//   gnt[3:0]   : registered one-hot grant
//   select0/1  : registered mux select = owner index
//   out        : owner's data bit, gated by out_valid (combinational)
//   out_valid  : |(gnt & req) (combinational)
// Build option: define MUX4_ARB_LOCK_EN to add the lock input.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MUX4_ARB_LOCK_EN
    input  logic               lock,
`endif
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic               select0,
    output logic               select1,
    output logic               out,
    output logic               out_valid
);

    localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;

    logic             hold;
    logic [IDX_W-1:0] pick_base;
    pick_t            pick;
    logic             expire;
    logic             mux_out;

`ifdef MUX4_ARB_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    // From IDLE the search starts after the rotation pointer; at the end of a
    // tenure it starts after the current owner, which makes the owner the last
    // candidate and only re-granted when nobody else is asking.
    assign pick_base = (state_q == ARB_GRANT) ? own_q : ptr_q;
    assign pick      = rr_pick(req, pick_base);
    assign expire    = (cnt_q == CNT_LAST) && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            own_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick.found) begin
                    state_d = ARB_GRANT;
                    own_d   = pick.idx;
                    cnt_d   = '0;
                    gnt_d   = NUM_REQ'(1) << pick.idx;
                    sel_d   = pick.idx;
                end
            end
            ARB_GRANT: begin
                if (req[own_q] && !expire) begin
                    // Under lock the counter parks at its last value.
                    if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                end else begin
                    ptr_d = own_q;
                    cnt_d = '0;
                    if (pick.found) begin
                        own_d = pick.idx;
                        gnt_d = NUM_REQ'(1) << pick.idx;
                        sel_d = pick.idx;
                    end else begin
                        // Selects keep their last value while idle.
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign select0   = sel_q[0];
    assign select1   = sel_q[1];
    assign out_valid = |(gnt_q & req);

    mux4 u_mux4 (
        .a       (din[0]),
        .b       (din[1]),
        .c       (din[2]),
        .d       (din[3]),
        .select0 (sel_q[0]),
        .select1 (sel_q[1]),
        .out     (mux_out)
    );

    // A releasing owner still holds gnt for one cycle; its data is not valid.
    assign out = mux_out & out_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter (MAX_BURST = 4). Expected output
// words {gnt, select1, select0, out_valid, out} are queued as stimulus is
// applied and popped when the DUT result is sampled on the falling edge.
// The lock scenario is included when MUX4_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] din   = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
    logic       lock  = 1'b0;
`endif

    logic [3:0] gnt;
    logic       select0, select1, out, out_valid;
    logic [7:0] obs;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    mux4_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX4_ARB_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .select0   (select0),
        .select1   (select1),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, select1, select0, out_valid, out};

    function automatic logic [7:0] mk(input int owner, input logic ov, input logic o);
        logic [3:0] g;
        logic [1:0] s;
        g = 4'b0001 << owner;
        s = 2'(owner);
        return {g, s, ov, o};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_q.push_back(8'h00);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", obs, e);
        end
        rst_n = 1'b1;
        exp_q.push_back(8'h00);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_idle: got %b want %b", obs, e);
        end
    endtask

    // Lone requester 2 keeps getting fresh bursts with no gap.
    task automatic test_single();
        for (int i = 0; i < 12; i++) begin
            req = 4'b0100;
            din = i[0] ? 4'b1011 : 4'b0100;
            exp_q.push_back(mk(2, 1'b1, ~i[0]));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL single[%0d]: got %b want %b", i, obs, e);
            end
        end
    endtask

    // Continues from test_single: owner 2 releases, bus idles, then 0 is
    // granted and is not preempted by a mid-tenure request from 1.
    task automatic test_idle_return();
        logic [3:0] rq [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                               4'b0011, 4'b0011, 4'b0011};
        logic [7:0] ex [7];
        ex[0] = {4'b0000, 2'b10, 1'b0, 1'b0};
        ex[1] = {4'b0000, 2'b10, 1'b0, 1'b0};
        ex[2] = mk(0, 1'b1, 1'b1);
        ex[3] = mk(0, 1'b1, 1'b1);
        ex[4] = mk(0, 1'b1, 1'b1);
        ex[5] = mk(0, 1'b1, 1'b1);
        ex[6] = mk(1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            req = rq[i];
            din = (i < 2) ? 4'b0100 : 4'b0001;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL idle_return[%0d]: got %b want %b", i, obs, e);
            end
        end
    endtask

    // Everyone requesting: owners 0,1,2,3,0 in 4-cycle tenures, no bubbles.
    task automatic test_all_req();
        int owner;
        do_reset();
        req = 4'b1111;
        din = 4'b1010;
        for (int i = 0; i < 20; i++) begin
            owner = (i / 4) % 4;
            exp_q.push_back(mk(owner, 1'b1, din[owner]));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL all_req[%0d]: got %b want %b", i, obs, e);
            end
        end
    endtask

    // Owner 1 releases after 2 cycles; grant skips idle requester 2 to 3.
    task automatic test_early_release();
        do_reset();
        req = 4'b1010;
        din = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(1, 1'b1, 1'b1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL early_rel_hold[%0d]: got %b want %b", i, obs, e);
            end
        end
        req = 4'b1000;
        exp_q.push_back(mk(1, 1'b0, 1'b0));
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL early_rel_cycle: got %b want %b", obs, e);
        end
        exp_q.push_back(mk(3, 1'b1, 1'b1));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL early_rel_handover: got %b want %b", obs, e);
        end
    endtask

    // Asynchronous reset during owner 2's tenure, then restart from 0.
    task automatic test_reset_mid();
        int owner;
        do_reset();
        req = 4'b1111;
        din = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            owner = i / 4;
            exp_q.push_back(mk(owner, 1'b1, din[owner]));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_mid_run[%0d]: got %b want %b", i, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_mid_async: got %b want %b", obs, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 1'b1, 1'b0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_mid_restart: got %b want %b", obs, e);
        end
    endtask

`ifdef MUX4_ARB_LOCK_EN
    // Lock holds owner 0 well past MAX_BURST; dropping it hands over to 1.
    task automatic test_lock();
        do_reset();
        req  = 4'b0011;
        din  = 4'b0001;
        lock = 1'b1;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(mk(0, 1'b1, 1'b1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL lock_hold[%0d]: got %b want %b", i, obs, e);
            end
        end
        lock = 1'b0;
        exp_q.push_back(mk(1, 1'b1, 1'b0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL lock_release: got %b want %b", obs, e);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_idle_return();
        test_all_req();
        test_early_release();
        test_reset_mid();
`ifdef MUX4_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
